// File: rtl/multi_task_fifo.sv
`default_nettype none
// ============================================================================
// Module   : multi_task_fifo
// Brief    : NCH independent task queues sharing one NCH x DEPTH storage
//            array. One write and one read port, each steered per cycle.
//            Adds write-through bypass on empty queues, per-channel
//            occupancy/flags, and drop/underflow pulses.
// Revision : 1.0 - initial release
// ============================================================================
module multi_task_fifo #(
  parameter  int DW     = 46,
  parameter  int NCH    = 4,
  parameter  int DEPTH  = 8,
  parameter  int AF_LVL = 6,
  localparam int CHW    = $clog2(NCH),
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [CHW-1:0]        wr_ch,
  input  logic [DW-1:0]         wr_data,
  input  logic                  rd_en,
  input  logic [CHW-1:0]        rd_ch,
  output logic [DW-1:0]         rd_data,
  output logic                  rd_valid,
  output logic [NCH-1:0]        empty,
  output logic [NCH-1:0]        full,
  output logic [NCH-1:0]        almost_full,
  output logic [NCH*(AW+1)-1:0] count,
  output logic                  wr_drop,
  output logic                  rd_underflow
);

  localparam logic [AW:0] C_FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_AF_CNT   = (AW+1)'(AF_LVL);

  // Shared storage; address is {channel, pointer}. Not reset.
  logic [DW-1:0] mem [NCH*DEPTH];

  logic [AW-1:0] wr_ptr_q [NCH];
  logic [AW-1:0] wr_ptr_d [NCH];
  logic [AW-1:0] rd_ptr_q [NCH];
  logic [AW-1:0] rd_ptr_d [NCH];
  logic [AW:0]   cnt_q    [NCH];
  logic [AW:0]   cnt_d    [NCH];

  logic [DW-1:0] rd_data_q,      rd_data_d;
  logic          rd_valid_q,     rd_valid_d;
  logic          wr_drop_q,      wr_drop_d;
  logic          rd_underflow_q, rd_underflow_d;

  logic          w_wr_ch_ok;
  logic          w_rd_ch_ok;
  logic [AW:0]   w_wr_cnt_sel;
  logic [AW:0]   w_rd_cnt_sel;
  logic [AW-1:0] w_wr_ptr_sel;
  logic [AW-1:0] w_rd_ptr_sel;
  logic          w_same;
  logic          w_wr_full;
  logic          w_wr_empty;
  logic          w_rd_empty;
  logic          w_wa;
  logic          w_ra;
  logic          w_bypass;
  logic [CHW+AW-1:0] w_wr_addr;
  logic [CHW+AW-1:0] w_rd_addr;

  // Channel selects beyond NCH only exist when NCH is not a power of two.
  if (NCH == (1 << CHW)) begin : g_ch_pow2
    assign w_wr_ch_ok = 1'b1;
    assign w_rd_ch_ok = 1'b1;
  end else begin : g_ch_range
    assign w_wr_ch_ok = ({1'b0, wr_ch} < (CHW+1)'(NCH));
    assign w_rd_ch_ok = ({1'b0, rd_ch} < (CHW+1)'(NCH));
  end

  // Pick the addressed channel's count and pointer for each port.
  always_comb begin
    w_wr_cnt_sel = '0;
    w_rd_cnt_sel = '0;
    w_wr_ptr_sel = '0;
    w_rd_ptr_sel = '0;
    for (int c = 0; c < NCH; c++) begin
      if (wr_ch == CHW'(c)) begin
        w_wr_cnt_sel = cnt_q[c];
        w_wr_ptr_sel = wr_ptr_q[c];
      end
      if (rd_ch == CHW'(c)) begin
        w_rd_cnt_sel = cnt_q[c];
        w_rd_ptr_sel = rd_ptr_q[c];
      end
    end
  end

  assign w_same     = wr_en & rd_en & (wr_ch == rd_ch);
  assign w_wr_full  = (w_wr_cnt_sel == C_FULL_CNT);
  assign w_wr_empty = (w_wr_cnt_sel == '0);
  assign w_rd_empty = (w_rd_cnt_sel == '0);
  // A same-channel pair is always accepted on a valid channel: on a full
  // queue the read frees the slot the write fills, on an empty one the word
  // is forwarded straight to the read port.
  assign w_wa       = wr_en & w_wr_ch_ok & (~w_wr_full  | w_same);
  assign w_ra       = rd_en & w_rd_ch_ok & (~w_rd_empty | w_same);
  assign w_bypass   = w_same & w_wr_ch_ok & w_wr_empty;
  assign w_wr_addr  = {wr_ch, w_wr_ptr_sel};
  assign w_rd_addr  = {rd_ch, w_rd_ptr_sel};

  // Next-state for pointers, counts and the registered read/error outputs.
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    cnt_d          = cnt_q;
    for (int c = 0; c < NCH; c++) begin
      logic inc;
      logic dec;
      inc = w_wa & ~w_bypass & (wr_ch == CHW'(c));
      dec = w_ra & ~w_bypass & (rd_ch == CHW'(c));
      if (inc) wr_ptr_d[c] = wr_ptr_q[c] + AW'(1);
      if (dec) rd_ptr_d[c] = rd_ptr_q[c] + AW'(1);
      cnt_d[c] = cnt_q[c] + (AW+1)'(inc) - (AW+1)'(dec);
    end
    rd_valid_d     = w_ra;
    rd_data_d      = '0;
    if (w_ra) begin
      rd_data_d = w_bypass ? wr_data : mem[w_rd_addr];
    end
    wr_drop_d      = wr_en & ~w_wa;
    rd_underflow_d = rd_en & ~w_ra;
  end

  // Storage write; a bypassed word never lands in memory.
  always_ff @(posedge clk) begin
    if (w_wa && !w_bypass) begin
      mem[w_wr_addr] <= wr_data;
    end
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q       <= '{default: '0};
      rd_ptr_q       <= '{default: '0};
      cnt_q          <= '{default: '0};
      rd_data_q      <= '0;
      rd_valid_q     <= 1'b0;
      wr_drop_q      <= 1'b0;
      rd_underflow_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      cnt_q          <= cnt_d;
      rd_data_q      <= rd_data_d;
      rd_valid_q     <= rd_valid_d;
      wr_drop_q      <= wr_drop_d;
      rd_underflow_q <= rd_underflow_d;
    end
  end

  // Per-channel flags decoded from the registered counts.
  for (genvar c = 0; c < NCH; c++) begin : g_flags
    assign empty[c]                   = (cnt_q[c] == '0);
    assign full[c]                    = (cnt_q[c] == C_FULL_CNT);
    assign almost_full[c]             = (cnt_q[c] >= C_AF_CNT);
    assign count[c*(AW+1) +: (AW+1)]  = cnt_q[c];
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign wr_drop      = wr_drop_q;
  assign rd_underflow = rd_underflow_q;

endmodule
`default_nettype wire

// File: doc/multi_task_fifo.md
# multi_task_fifo

Multi-channel task FIFO: NCH independent FIFO queues (one per tree), all in a single NCH×DEPTH storage array, with one write port and one read port. Each port selects its channel per cycle. It sits between the task dispatcher and the per-tree vPIFO engines. Relative to the single-queue task FIFO, it adds:
- channel count as a parameter;
- per-channel occupancy and almost-full flags;
- defined write-through bypass on an empty queue;
- explicit drop and underflow reporting.

## Interface
- DW, default 46: task word width (payload + meta + length + tree ids + 2 flag bits).
- NCH, default 4: number of channels. Must be ≥2.
- DEPTH, default 8: entries per channel. Must be a power of 2, ≥2.
- AF_LVL, default 6: almost-full threshold. Range 1..DEPTH.
- Derived: CHW = $clog2(NCH); AW = $clog2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request.
- wr_ch  in  CHW  target channel for the write.
- wr_data  in  DW  task word to write.
- rd_en  in  1  read request.
- rd_ch  in  CHW  source channel for the read.
- rd_data  out  DW  registered read data. Zero whenever rd_valid is 0.
- rd_valid  out  1  rd_data holds the result of the read accepted in the previous cycle.
- empty  out  NCH  per-channel empty, bit c = channel c.
- full  out  NCH  per-channel full.
- almost_full  out  NCH  per-channel count ≥ AF_LVL.
- count  out  NCH*(AW+1)  per-channel occupancy. Channel c occupies bits [c*(AW+1) +: AW+1].
- wr_drop  out  1  one-cycle pulse: a write request was rejected.
- rd_underflow  out  1  one-cycle pulse: a read request was rejected.

## Operation
- Per-channel state: wr_ptr[c] and rd_ptr[c] (AW bits each, wrap modulo DEPTH) and cnt[c] (AW+1 bits). Storage address is {ch, ptr}.
- Definition: same = wr_en & rd_en & (wr_ch == rd_ch).
- Write accept: wa = wr_en & (!full[wr_ch] | same).
- Read accept: ra = rd_en & (!empty[rd_ch] | same).
- Normal write (wa, not bypass): mem[{wr_ch, wr_ptr}] ← wr_data; wr_ptr[wr_ch] increments.
- Normal read (ra, not bypass): rd_data ← mem[{rd_ch, rd_ptr}]; rd_ptr[rd_ch] increments.
- Bypass: same & empty[wr_ch].
  - rd_data ← wr_data next cycle.
  - No memory write, no pointer change, count stays 0.
- same on a full channel: both accepted. The read takes the oldest entry and the write fills the freed slot. Count stays DEPTH.
- same on a partially filled channel: both accepted; count unchanged. Reads return the old head, never the word written in the same cycle.
- Different channels: write and read are independent. Each channel's count moves by ±1.
- Counting: cnt[c] += (wa & wr_ch==c & !bypass) − (ra & rd_ch==c & !bypass).
- Rejected write (wr_en & !wa): data discarded, wr_drop = 1 next cycle.
- Rejected read (rd_en & !ra): rd_valid = 0 and rd_data = 0 next cycle; rd_underflow = 1 next cycle.
- Flags are decoded combinationally from registered cnt[c]:
  - empty = (cnt == 0);
  - full = (cnt == DEPTH);
  - almost_full = (cnt ≥ AF_LVL).
- No FSM. Control is the per-channel counter/pointer state only.

## Timing
- Read latency is 1 cycle: a read accepted at edge N gives rd_valid = 1 and valid rd_data after edge N+1, stable for one cycle.
- Back-to-back reads on any channel mix are allowed every cycle. Throughput is 1 write + 1 read per cycle.
- A write accepted at edge N is visible in count, empty and full after edge N. It is readable by a read request presented in cycle N+1.
- Reset asserted (rst = 0), asynchronously:
  - all pointers and counts = 0;
  - empty = all ones; full = 0; almost_full = 0;
  - rd_valid = 0; rd_data = 0; wr_drop = 0; rd_underflow = 0.
- Memory contents are not reset.
- Reset asserted mid-operation discards all queued data and any in-flight rd_valid immediately.
- First accepted operation is at the first rising edge after rst deasserts. The deassertion edge must be synchronous to clk.
- wr_ch or rd_ch ≥ NCH (NCH not a power of 2): the request is treated as rejected and the matching error pulse fires.

## Test plan
- Fill and drain one channel: reset, write 0x1..0x8 to ch2 on consecutive cycles → full[2] = 1, count ch2 = 8, almost_full[2] = 1 from the 6th write. Read ch2 ×8 → rd_data 0x1..0x8 in order, each 1 cycle after its rd_en. empty[2] = 1 at the end.
- Channel isolation: interleave writes A0..A3 to ch0 and B0..B3 to ch3, then read ch3, ch0, ch3, ch0 → B0, A0, B1, A1. Counts ch0 = 2, ch3 = 2.
- Bypass: ch1 empty, wr_en + rd_en on ch1 with wr_data = 0xABC → next cycle rd_valid = 1, rd_data = 0xABC; count ch1 stays 0, empty[1] = 1.
- Full with simultaneous same-channel access: ch0 full with 0..7, write 0x99 + read ch0 → rd_data = 0, count stays 8. Subsequent 8 reads return 1..7 then 0x99.
- Errors: write to full ch0 → wr_drop pulses 1 cycle, count unchanged. Read from empty ch3 → rd_underflow pulses, rd_valid = 0, rd_data = 0.
- Reset mid-stream: ch0 = 5 entries, a read accepted, then rst = 0 asynchronously before the next edge → rd_valid = 0 immediately, all counts 0. After release, a read on ch0 gives rd_underflow.
